branch_pc_unit: RTL

- Consumer side of the D-stage comparator flags: takes D_equal / D_equal_0 / D_great_0 plus the decoded branch type, resolves taken/not-taken, and computes the redirect target.
- Owns the F-stage PC register.
- Produces the link value for bgezal/jal/jalr.
- Keeps branch statistics counters for the test bench.
- MIPS delay-slot semantics: no flush; the instruction already in F (D_pc+4) always executes.

---
 rtl/branch_pc_unit.sv | 110 +++++++++++
 1 files changed

// File: rtl/branch_pc_unit.sv
// D-stage branch resolution and F-stage PC register for a MIPS-style pipeline with delay slots.
// Also produces the link value and keeps saturating branch/taken statistics counters.
module branch_pc_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [3:0]  D_br_type,
    input  logic        D_equal,
    input  logic        D_equal_0,
    input  logic        D_great_0,
    input  logic [31:0] D_pc,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_instr_index,
    input  logic [31:0] D_rs_data,
    output logic [31:0] F_pc,
    output logic        F_pc_adel,
    output logic        D_taken,
    output logic [31:0] D_npc,
    output logic        D_link_en,
    output logic [31:0] D_link_pc,
    output logic [31:0] br_count,
    output logic [31:0] taken_count
);

    typedef enum logic [3:0] {
        BrNone, BrBeq, BrBne, BrBlez, BrBgtz, BrBltz, BrBgez, BrBgezal,
        BrJ, BrJal, BrJr, BrJalr
    } br_type_e;

    logic [31:0] f_pc_q;
    logic [31:0] br_count_q;
    logic [31:0] taken_count_q;
    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] target;
    logic        is_branch;

    assign pc_plus4  = D_pc + 32'd4;
    assign br_target = pc_plus4 + {{14{D_imm16[15]}}, D_imm16, 2'b00};
    assign j_target  = {pc_plus4[31:28], D_instr_index, 2'b00};

    always_comb begin
        D_taken   = 1'b0;
        target    = br_target;
        is_branch = 1'b1;
        D_link_en = 1'b0;
        case (br_type_e'(D_br_type))
            BrBeq:    D_taken = D_equal;
            BrBne:    D_taken = !D_equal;
            BrBlez:   D_taken = !D_great_0 || D_equal_0;
            BrBgtz:   D_taken = D_great_0 && !D_equal_0;
            BrBltz:   D_taken = !D_great_0;
            BrBgez:   D_taken = D_great_0;
            BrBgezal: begin
                D_taken   = D_great_0;
                D_link_en = 1'b1;
            end
            BrJ: begin
                D_taken = 1'b1;
                target  = j_target;
            end
            BrJal: begin
                D_taken   = 1'b1;
                target    = j_target;
                D_link_en = 1'b1;
            end
            BrJr: begin
                D_taken = 1'b1;
                target  = D_rs_data;
            end
            BrJalr: begin
                D_taken   = 1'b1;
                target    = D_rs_data;
                D_link_en = 1'b1;
            end
            default:  is_branch = 1'b0;
        endcase
    end

    // Not-taken falls through from the fetch PC, not D_pc: the delay slot is already in F.
    assign D_npc     = D_taken ? target : f_pc_q + 32'd4;
    assign D_link_pc = D_pc + 32'd8;

    assign F_pc        = f_pc_q;
    assign F_pc_adel   = (f_pc_q[1:0] != 2'b00) || (f_pc_q < PC_LO) || (f_pc_q > PC_HI);
    assign br_count    = br_count_q;
    assign taken_count = taken_count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            f_pc_q        <= PC_RESET;
            br_count_q    <= 32'd0;
            taken_count_q <= 32'd0;
        end else if (!stall) begin
            f_pc_q <= D_npc;
            if (is_branch && (br_count_q != 32'hFFFF_FFFF)) begin
                br_count_q <= br_count_q + 32'd1;
            end
            if (D_taken && (taken_count_q != 32'hFFFF_FFFF)) begin
                taken_count_q <= taken_count_q + 32'd1;
            end
        end
    end

endmodule
